dz_image_select: RTL

//  Maps the egg-hatch game stage number to a dot-matrix image index for dz_show.
//  Pre-hatch stages map to crack images; the hatch stage picks one of N_ANIMALS

---
 rtl/dz_image_select_if.sv | 28 ++
 rtl/dz_image_select.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dz_image_select_if.sv
// Stage-to-image bus between the game-control FSM and dz_image_select.
// The master drives load/stage/fail. The slave returns the image and colour selects.
interface dz_image_select_if #(
    parameter int STAGE_W = 5,
    parameter int IMG_W   = 4
);
    logic               load;
    logic [STAGE_W-1:0] stage_num;
    logic               fail;
    logic [IMG_W-1:0]   img_idx;
    logic               img_valid;
    logic               animal_lck;
    logic               range_err;
    logic               col_g_en;
    logic               col_r_en;

    modport master (
        output load, stage_num, fail,
        input  img_idx, img_valid, animal_lck,
        input  range_err, col_g_en, col_r_en
    );

    modport slave (
        input  load, stage_num, fail,
        output img_idx, img_valid, animal_lck,
        output range_err, col_g_en, col_r_en
    );
endinterface

// File: rtl/dz_image_select.sv
// Maps the egg-hatch stage number to a dz_show image index and matrix colour.
// DZ_BLINK_EN: when defined, the green columns blink every BLINK_DIV cycles while failing.
module dz_image_select #(
    parameter int          STAGE_W     = 5,
    parameter int          HATCH_STAGE = 16,
    parameter int          STAGE_SHIFT = 1,
    parameter int          ANIMAL_BASE = 8,
    parameter int          N_ANIMALS   = 4,
    parameter int          IMG_W       = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
`ifdef DZ_BLINK_EN
    , parameter int        BLINK_DIV   = 25_000_000
`endif
) (
    input logic              clk,
    input logic              rst,
    dz_image_select_if.slave bus
);
    localparam int AW = (N_ANIMALS > 1) ? $clog2(N_ANIMALS) : 1;
    localparam logic [AW:0]          NA    = N_ANIMALS[AW:0];
    localparam logic [STAGE_W-1:0]   HATCH = HATCH_STAGE[STAGE_W-1:0];
    localparam logic [IMG_W-1:0]     BASE  = ANIMAL_BASE[IMG_W-1:0];

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          r_state;
    logic [15:0]     r_lfsr;
    logic [AW-1:0]   r_animal;
    logic [IMG_W-1:0] r_img;
    logic            r_valid;
    logic            r_lck;
    logic            r_rerr;
    logic            r_g;
    logic            r_r;

    logic            w_fb;
    logic [AW-1:0]   w_raw;
    logic [AW:0]     w_sub;
    logic [AW-1:0]   w_anim;
    logic            w_lt;
    logic            w_eq;
    logic            w_gt;

    // Fibonacci taps 16,14,13,11; the nonzero seed keeps it off the all-zero state
    assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_raw  = r_lfsr[AW-1:0];
    assign w_sub  = {1'b0, w_raw} - NA;
    assign w_anim = ({1'b0, w_raw} >= NA) ? w_sub[AW-1:0] : w_raw;

    assign w_lt = (bus.stage_num <  HATCH);
    assign w_eq = (bus.stage_num == HATCH);
    assign w_gt = (bus.stage_num >  HATCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lfsr   <= LFSR_SEED;
            r_animal <= '0;
            r_img    <= '0;
            r_valid  <= 1'b0;
            r_lck    <= 1'b0;
            r_rerr   <= 1'b0;
        end else begin
            r_lfsr  <= {r_lfsr[14:0], w_fb};
            r_valid <= 1'b0;
            r_rerr  <= 1'b0;
            if (bus.load) begin
                unique case (1'b1)
                    w_lt: begin
                        r_img   <= IMG_W'(bus.stage_num >> STAGE_SHIFT);
                        r_state <= IDLE;
                        r_lck   <= 1'b0;
                        r_valid <= 1'b1;
                    end
                    w_eq: begin
                        r_state <= LOCKED;
                        r_lck   <= 1'b1;
                        r_valid <= 1'b1;
                        if (r_state == IDLE) begin
                            r_animal <= w_anim;
                            r_img    <= BASE + IMG_W'(w_anim);
                        end else begin
                            r_img    <= BASE + IMG_W'(r_animal);
                        end
                    end
                    w_gt: begin
                        r_rerr <= 1'b1;
                    end
                    default: begin
                        r_rerr <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef DZ_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CMAX = CW'(BLINK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // r_r high means fail was low last cycle, so it marks the first fail cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g   <= 1'b0;
            r_r   <= 1'b1;
            r_cnt <= '0;
        end else if (!bus.fail) begin
            r_g   <= 1'b0;
            r_r   <= 1'b1;
            r_cnt <= '0;
        end else begin
            r_r <= 1'b0;
            if (r_r) begin
                r_g   <= 1'b1;
                r_cnt <= '0;
            end else if (r_cnt == CMAX) begin
                r_g   <= ~r_g;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g <= 1'b0;
            r_r <= 1'b1;
        end else begin
            r_g <= bus.fail;
            r_r <= ~bus.fail;
        end
    end
`endif

    assign bus.img_idx    = r_img;
    assign bus.img_valid  = r_valid;
    assign bus.animal_lck = r_lck;
    assign bus.range_err  = r_rerr;
    assign bus.col_g_en   = r_g;
    assign bus.col_r_en   = r_r;
endmodule
